// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - VGA 640x480@60 timing constants, colours and reset snapshot for the Pong renderer
package pong_pkg;

    localparam logic [9:0] SCREEN_WIDTH  = 10'd640;
    localparam logic [9:0] SCREEN_HEIGHT = 10'd480;

    localparam logic [9:0] H_FRONT_PORCH = 10'd16;
    localparam logic [9:0] H_SYNC_PULSE  = 10'd96;
    localparam logic [9:0] H_BACK_PORCH  = 10'd48;
    localparam logic [9:0] H_TOTAL       = SCREEN_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam logic [9:0] H_SYNC_START  = SCREEN_WIDTH + H_FRONT_PORCH;
    localparam logic [9:0] H_SYNC_END    = H_SYNC_START + H_SYNC_PULSE;

    localparam logic [9:0] V_FRONT_PORCH = 10'd10;
    localparam logic [9:0] V_SYNC_PULSE  = 10'd2;
    localparam logic [9:0] V_BACK_PORCH  = 10'd33;
    localparam logic [9:0] V_TOTAL       = SCREEN_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam logic [9:0] V_SYNC_START  = SCREEN_HEIGHT + V_FRONT_PORCH;
    localparam logic [9:0] V_SYNC_END    = V_SYNC_START + V_SYNC_PULSE;

    localparam logic [5:0] COLOR_BALL       = 6'b111111;
    localparam logic [5:0] COLOR_PADDLE     = 6'b001100;
    localparam logic [5:0] COLOR_OPP_PADDLE = 6'b110000;
    localparam logic [5:0] COLOR_NET        = 6'b101010;
    localparam logic [5:0] COLOR_BACKGROUND = 6'b000000;

    localparam logic [9:0] RESET_BALL_X   = 10'd320;
    localparam logic [9:0] RESET_BALL_Y   = 10'd240;
    localparam logic [9:0] RESET_PADDLE_Y = 10'd210;

    typedef struct packed {
        logic [9:0] ball_x;
        logic [9:0] ball_y;
        logic [9:0] paddle_y;
        logic [9:0] opp_paddle_y;
    } snapshot_t;

    localparam snapshot_t RESET_SNAPSHOT = '{
        ball_x:       RESET_BALL_X,
        ball_y:       RESET_BALL_Y,
        paddle_y:     RESET_PADDLE_Y,
        opp_paddle_y: RESET_PADDLE_Y
    };

    // 11-bit compare so start+size cannot wrap for any 10-bit position
    function automatic logic in_span(input logic [10:0] pos, input logic [10:0] start,
                                     input logic [10:0] size);
        return (pos >= start) && (pos < start + size);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 800x525 h/v counters with raw sync, active and frame strobes
module vga_timing
    import pong_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic [9:0] o_h,
    output logic [9:0] o_v,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_active,
    output logic       o_frame_start,
    output logic       o_frame_load
);

    logic [9:0] r_h;
    logic [9:0] r_v;
    logic       w_h_last;
    logic       w_v_last;

    assign w_h_last = (r_h == H_TOTAL - 10'd1);
    assign w_v_last = (r_v == V_TOTAL - 10'd1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else begin
            r_h <= w_h_last ? '0 : r_h + 10'd1;
            if (w_h_last) begin
                r_v <= w_v_last ? '0 : r_v + 10'd1;
            end
        end
    end

    assign o_h           = r_h;
    assign o_v           = r_v;
    assign o_hsync       = !((r_h >= H_SYNC_START) && (r_h < H_SYNC_END));
    assign o_vsync       = !((r_v >= V_SYNC_START) && (r_v < V_SYNC_END));
    assign o_active      = (r_h < SCREEN_WIDTH) && (r_v < SCREEN_HEIGHT);
    assign o_frame_start = (r_h == '0) && (r_v == SCREEN_HEIGHT);
    // High on the edge that moves the counters into (0, 480)
    assign o_frame_load  = w_h_last && (r_v == SCREEN_HEIGHT - 10'd1);

endmodule

// File: rtl/pong_video_gen.sv
// rtl/pong_video_gen.sv - Pong playfield renderer; optional dashed centre net under PONG_CENTER_NET_EN
module pong_video_gen
    import pong_pkg::*;
#(
    parameter int BALL_SIZE     = 10,
    parameter int PADDLE_WIDTH  = 10,
    parameter int PADDLE_HEIGHT = 60,
    parameter int PADDLE_X      = 0,
    parameter int OPP_PADDLE_X  = 630
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] paddle_y,
    input  logic [9:0] opp_paddle_y,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb,
    output logic       video_active,
    output logic       frame_tick
);

    logic [9:0]  w_h;
    logic [9:0]  w_v;
    logic        w_hsync;
    logic        w_vsync;
    logic        w_active;
    logic        w_frame_start;
    logic        w_frame_load;
    logic [10:0] w_h11;
    logic [10:0] w_v11;
    logic        w_ball_hit;
    logic        w_paddle_hit;
    logic        w_opp_hit;
    logic        w_net_hit;
    logic [5:0]  w_rgb;
    snapshot_t   r_snap;

    vga_timing u_timing (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_h           (w_h),
        .o_v           (w_v),
        .o_hsync       (w_hsync),
        .o_vsync       (w_vsync),
        .o_active      (w_active),
        .o_frame_start (w_frame_start),
        .o_frame_load  (w_frame_load)
    );

    // Positions are frozen for a whole frame so objects never tear mid-scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap <= RESET_SNAPSHOT;
        end else if (w_frame_load) begin
            r_snap <= '{ball_x: ball_x, ball_y: ball_y, paddle_y: paddle_y,
                        opp_paddle_y: opp_paddle_y};
        end
    end

    assign w_h11 = {1'b0, w_h};
    assign w_v11 = {1'b0, w_v};

    assign w_ball_hit   = in_span(w_h11, {1'b0, r_snap.ball_x}, 11'(BALL_SIZE)) &&
                          in_span(w_v11, {1'b0, r_snap.ball_y}, 11'(BALL_SIZE));
    assign w_paddle_hit = in_span(w_h11, 11'(PADDLE_X), 11'(PADDLE_WIDTH)) &&
                          in_span(w_v11, {1'b0, r_snap.paddle_y}, 11'(PADDLE_HEIGHT));
    assign w_opp_hit    = in_span(w_h11, 11'(OPP_PADDLE_X), 11'(PADDLE_WIDTH)) &&
                          in_span(w_v11, {1'b0, r_snap.opp_paddle_y}, 11'(PADDLE_HEIGHT));

`ifdef PONG_CENTER_NET_EN
    assign w_net_hit = ((w_h == 10'd319) || (w_h == 10'd320)) && !w_v[4];
`else
    assign w_net_hit = 1'b0;
`endif

    always_comb begin
        w_rgb = COLOR_BACKGROUND;
        if (w_active) begin
            if (w_ball_hit) begin
                w_rgb = COLOR_BALL;
            end else if (w_paddle_hit) begin
                w_rgb = COLOR_PADDLE;
            end else if (w_opp_hit) begin
                w_rgb = COLOR_OPP_PADDLE;
            end else if (w_net_hit) begin
`ifdef PONG_CENTER_NET_EN
                w_rgb = COLOR_NET;
`else
                w_rgb = COLOR_BACKGROUND;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            rgb          <= '0;
            video_active <= 1'b0;
            frame_tick   <= 1'b0;
        end else begin
            hsync        <= w_hsync;
            vsync        <= w_vsync;
            rgb          <= w_rgb;
            video_active <= w_active;
            frame_tick   <= w_frame_start;
        end
    end

endmodule

// File: tb/tb_pong_video_gen.sv
// tb/tb_pong_video_gen.sv - scoreboard bench for pong_video_gen against a frame-position reference model
module tb_pong_video_gen;

    localparam int H_TOT      = 800;
    localparam int V_TOT      = 525;
    localparam int FRAME      = H_TOT * V_TOT;
    localparam int LOAD_INDEX = 480 * H_TOT - 1;
    localparam int BALL       = 10;
    localparam int PW         = 10;
    localparam int PH         = 60;
    localparam int PX         = 0;
    localparam int OPX        = 630;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] ball_x = '0;
    logic [9:0] ball_y = '0;
    logic [9:0] paddle_y = '0;
    logic [9:0] opp_paddle_y = '0;
    logic       hsync;
    logic       vsync;
    logic [5:0] rgb;
    logic       video_active;
    logic       frame_tick;

    pong_video_gen #(
        .BALL_SIZE     (BALL),
        .PADDLE_WIDTH  (PW),
        .PADDLE_HEIGHT (PH),
        .PADDLE_X      (PX),
        .OPP_PADDLE_X  (OPX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .paddle_y     (paddle_y),
        .opp_paddle_y (opp_paddle_y),
        .hsync        (hsync),
        .vsync        (vsync),
        .rgb          (rgb),
        .video_active (video_active),
        .frame_tick   (frame_tick)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic       tick;
        logic [5:0] rgb;
    } out_t;

    out_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;
    int   snap_bx = 320, snap_by = 240, snap_py = 210, snap_oy = 210;
    int   mc = 0;
    int   mk = 0;
    int   last_tick = 0;
    int   ticks = 0;
    int   e_cnt = 0;

    function automatic logic [5:0] ref_pixel(int h, int v, int bx, int by, int py, int oy);
        if (h >= 640 || v >= 480) return 6'b000000;
        if (h >= bx && h < bx + BALL && v >= by && v < by + BALL) return 6'b111111;
        if (h >= PX && h < PX + PW && v >= py && v < py + PH) return 6'b001100;
        if (h >= OPX && h < OPX + PW && v >= oy && v < oy + PH) return 6'b110000;
`ifdef PONG_CENTER_NET_EN
        if ((h == 319 || h == 320) && (v % 32) < 16) return 6'b101010;
`endif
        return 6'b000000;
    endfunction

    task automatic finish_sim();
        if (!done) begin
            done = 1'b1;
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    endtask

    task automatic check(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Reference: output k reflects frame position k-1; snapshot taken as position 479*800+799 ends
    always @(posedge clk) begin : model
        int   p;
        int   h;
        int   v;
        out_t e;
        if (!rst_n) begin
            mc = 0;
            snap_bx = 320; snap_by = 240; snap_py = 210; snap_oy = 210;
        end else begin
            p = mc % FRAME;
            h = p % H_TOT;
            v = p / H_TOT;
            e.hs   = !(h >= 656 && h < 752);
            e.vs   = !(v >= 490 && v < 492);
            e.act  = (h < 640) && (v < 480);
            e.tick = (h == 0) && (v == 480);
            e.rgb  = ref_pixel(h, v, snap_bx, snap_by, snap_py, snap_oy);
            sb.push_back(e);
            if (p == LOAD_INDEX) begin
                snap_bx = int'(ball_x);
                snap_by = int'(ball_y);
                snap_py = int'(paddle_y);
                snap_oy = int'(opp_paddle_y);
            end
            mc++;
        end
    end

    always @(negedge clk) begin : monitor
        out_t e;
        out_t a;
        int   p;
        if (!rst_n) begin
            sb.delete();
            mk = 0;
            last_tick = 0;
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {hsync, vsync, video_active, frame_tick, rgb};
            mk++;
            p = (mk - 1) % FRAME;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL pixel out#%0d h=%0d v=%0d: got hs=%b vs=%b act=%b tick=%b rgb=%b, want hs=%b vs=%b act=%b tick=%b rgb=%b",
                         mk, p % H_TOT, p / H_TOT, a.hs, a.vs, a.act, a.tick, a.rgb,
                         e.hs, e.vs, e.act, e.tick, e.rgb);
            end
            if (frame_tick) begin
                ticks++;
                checks++;
                if ((last_tick == 0) ? (mk != 384001) : (mk - last_tick != FRAME)) begin
                    errors++;
                    $display("FAIL frame_tick_spacing: got tick at out#%0d (previous %0d), want first at 384001 then every %0d",
                             mk, last_tick, FRAME);
                end
                last_tick = mk;
            end
            if (errors >= 20) finish_sim();
        end
    end

    task automatic run_to(int t);
        while (e_cnt < t) begin
            @(negedge clk);
            e_cnt++;
        end
    endtask

    task automatic set_inputs(int bx, int by, int py, int oy);
        ball_x       = 10'(bx);
        ball_y       = 10'(by);
        paddle_y     = 10'(py);
        opp_paddle_y = 10'(oy);
    endtask

    task automatic jitter_until(int t);
        int step;
        while (e_cnt < t) begin
            step = int'($urandom_range(1, 4000));
            run_to((e_cnt + step < t) ? e_cnt + step : t);
            if (e_cnt < t) begin
                set_inputs(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                           int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            end
        end
    endtask

    initial begin : stimulus
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        e_cnt = 0;

        n = 0;
        while (hsync && n < 800) begin
            @(negedge clk);
            n++;
        end
        check("hsync_low_before_reset", int'(hsync), 0);

        #5 rst_n = 1'b0;
        #1;
        check("reset_hsync", int'(hsync), 1);
        check("reset_vsync", int'(vsync), 1);
        check("reset_rgb", int'(rgb), 0);
        check("reset_video_active", int'(video_active), 0);
        check("reset_frame_tick", int'(frame_tick), 0);

        repeat (3) @(negedge clk);
        set_inputs(100, 50, 400, 450);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (hsync && n < 1000);
        check("first_hsync_fall_edge", n, 657);
        @(negedge clk);
        e_cnt = n;

        run_to(384000);
        jitter_until(580000);
        set_inputs(0, 210, 210, int'($urandom_range(0, 1023)));
        run_to(804000);
        jitter_until(1000000);
        set_inputs(700, int'($urandom_range(0, 100)), int'($urandom_range(0, 479)),
                   int'($urandom_range(0, 479)));
        run_to(1224000);
        jitter_until(1356000);
        repeat (2) @(negedge clk);
        check("frame_tick_count", ticks, 3);
        finish_sim();
    end

endmodule
